game_ctrl: RTL and testbench



---
 rtl/game_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_game_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/game_ctrl.sv
// game_ctrl: game sequencer ahead of the bird motion block.
// It debounces the start, jump and down buttons, runs the IDLE/READY/PLAY/OVER
// state machine, and keeps the score, the high score and the gravity level.
// The buttons are assumed to be already synchronous to clk.
`timescale 1ns/1ps
module game_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int GROUND_CYCLES   = 64,
  parameter int OVER_CYCLES     = 1024,
  parameter int LEVEL_STEP      = 10,
  parameter int SCORE_MAX       = 999
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_start,
  input  logic               btn_jump,
  input  logic               btn_down,
  input  logic               collision,
  input  logic               pipe_passed,
  input  logic signed [10:0] y_coord,
  output logic [1:0]         state,
  output logic               enable,
  output logic               jump,
  output logic               down,
  output logic [1:0]         fall_accel,
  output logic [9:0]         score,
  output logic [9:0]         high_score
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES);
  localparam int GW  = $clog2(GROUND_CYCLES);
  localparam int OW  = $clog2(OVER_CYCLES);

  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [GW-1:0]  G_LAST  = GW'(GROUND_CYCLES - 1);
  localparam logic [OW-1:0]  O_LAST  = OW'(OVER_CYCLES - 1);
  localparam logic [9:0]     S_MAX   = 10'(SCORE_MAX);
  localparam logic [9:0]     LVL1    = 10'(LEVEL_STEP);
  localparam logic [9:0]     LVL2    = 10'(2 * LEVEL_STEP);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READY = 2'd1,
    S_PLAY  = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  // Button index order: 0 = start, 1 = jump, 2 = down.
  logic [2:0]            raw;
  logic [2:0]            db_lvl_q, db_lvl_d;
  logic [2:0][DBW-1:0]   db_cnt_q, db_cnt_d;
  logic                  start_press, jump_press;

  state_t                state_q, state_d;
  logic                  paused_q, paused_d;
  logic [GW-1:0]         gnd_q, gnd_d;
  logic [OW-1:0]         otmr_q, otmr_d;
  logic [9:0]            score_q, score_d;
  logic [9:0]            hs_q, hs_d;
  logic [1:0]            fa_q, fa_d;

  logic                  run;
  logic                  grounded;

  assign raw = {btn_down, btn_jump, btn_start};

  // A press fires on the same edge the debounced level rises, so the FSM
  // reacts exactly DEBOUNCE_CYCLES cycles after a clean raw edge.
  assign start_press = btn_start & ~db_lvl_q[0] & (db_cnt_q[0] == DB_LAST);
  assign jump_press  = btn_jump  & ~db_lvl_q[1] & (db_cnt_q[1] == DB_LAST);

  // Negative heights count as being on the ground.
  assign grounded = y_coord[10] || (y_coord == 11'sd0);
  assign run      = (state_q == S_PLAY) && !paused_q;

  // Debounce: count while raw disagrees with the level, flip on the last count.
  always_comb begin
    db_lvl_d = db_lvl_q;
    db_cnt_d = db_cnt_q;
    for (int i = 0; i < 3; i++) begin
      if (raw[i] != db_lvl_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          db_lvl_d[i] = raw[i];
          db_cnt_d[i] = '0;
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end else begin
        db_cnt_d[i] = '0;
      end
    end
  end

  // Game FSM, score, high score, ground counter and over timer.
  always_comb begin
    state_d  = state_q;
    paused_d = paused_q;
    gnd_d    = '0;
    otmr_d   = '0;
    score_d  = score_q;
    hs_d     = hs_q;

    // Score is updated before the game-over check so a pipe cleared on the
    // colliding cycle still counts toward the high score.
    if (run && pipe_passed && (score_q != S_MAX)) begin
      score_d = score_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start_press) begin
          state_d = S_READY;
          score_d = '0;
        end
      end
      S_READY: begin
        if (jump_press) begin
          state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        if (run && grounded) begin
          gnd_d = gnd_q + 1'b1;
        end
        if (run && (collision || (grounded && (gnd_q == G_LAST)))) begin
          state_d  = S_OVER;
          paused_d = 1'b0;
          gnd_d    = '0;
          if (score_d > hs_q) begin
            hs_d = score_d;
          end
        end else if (start_press) begin
          paused_d = ~paused_q;
        end
      end
      S_OVER: begin
        otmr_d = otmr_q + 1'b1;
        if (start_press || (otmr_q == O_LAST)) begin
          state_d = S_IDLE;
          otmr_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Gravity level follows the registered score one cycle later.
  always_comb begin
    if (score_q >= LVL2) begin
      fa_d = 2'd3;
    end else if (score_q >= LVL1) begin
      fa_d = 2'd2;
    end else begin
      fa_d = 2'd1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_lvl_q <= '0;
      db_cnt_q <= '0;
      state_q  <= S_IDLE;
      paused_q <= 1'b0;
      gnd_q    <= '0;
      otmr_q   <= '0;
      score_q  <= '0;
      hs_q     <= '0;
      fa_q     <= 2'd1;
    end else begin
      db_lvl_q <= db_lvl_d;
      db_cnt_q <= db_cnt_d;
      state_q  <= state_d;
      paused_q <= paused_d;
      gnd_q    <= gnd_d;
      otmr_q   <= otmr_d;
      score_q  <= score_d;
      hs_q     <= hs_d;
      fa_q     <= fa_d;
    end
  end

  assign state      = state_q;
  assign enable     = (state_q == S_READY) || run;
  assign jump       = db_lvl_q[1] && (state_q == S_PLAY);
  assign down       = db_lvl_q[2] && (state_q == S_PLAY);
  assign fall_accel = fa_q;
  assign score      = score_q;
  assign high_score = hs_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed testbench for game_ctrl: button debounce, sequencing, scoring,
// ground timeout, pause, game over / high score, and reset.
`timescale 1ns/1ps
module tb_game_ctrl;

  logic               clk;
  logic               rst;
  logic               btn_start;
  logic               btn_jump;
  logic               btn_down;
  logic               collision;
  logic               pipe_passed;
  logic signed [10:0] y_coord;
  logic [1:0]         state;
  logic               enable;
  logic               jump;
  logic               down;
  logic [1:0]         fall_accel;
  logic [9:0]         score;
  logic [9:0]         high_score;

  int errors = 0;
  int checks = 0;

  game_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .btn_start   (btn_start),
    .btn_jump    (btn_jump),
    .btn_down    (btn_down),
    .collision   (collision),
    .pipe_passed (pipe_passed),
    .y_coord     (y_coord),
    .state       (state),
    .enable      (enable),
    .jump        (jump),
    .down        (down),
    .fall_accel  (fall_accel),
    .score       (score),
    .high_score  (high_score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Clean start press: level rises on the 16th edge, then a clean release.
  task automatic press_start();
    btn_start = 1'b1;
    tick(16);
    btn_start = 1'b0;
    tick(16);
  endtask

  task automatic press_jump();
    btn_jump = 1'b1;
    tick(16);
    btn_jump = 1'b0;
    tick(16);
  endtask

  task automatic pulses(input int n);
    repeat (n) begin
      pipe_passed = 1'b1;
      tick(1);
      pipe_passed = 1'b0;
      tick(1);
    end
  endtask

  initial begin
    rst = 1'b1; btn_start = 1'b0; btn_jump = 1'b0; btn_down = 1'b0;
    collision = 1'b0; pipe_passed = 1'b0; y_coord = 11'sd100;
    tick(2);
    rst = 1'b0;
    chk("init_state", 32'(state), 0);
    chk("init_enable", 32'(enable), 0);
    chk("init_fa", 32'(fall_accel), 1);
    chk("init_score", 32'(score), 0);

    // Debounce: short glitch is filtered.
    btn_start = 1'b1; tick(5); btn_start = 1'b0; tick(20);
    chk("glitch_state", 32'(state), 0);

    // Clean hold: READY exactly 16 cycles after the raw edge.
    btn_start = 1'b1;
    tick(15);
    chk("hold15_state", 32'(state), 0);
    tick(1);
    chk("hold16_state", 32'(state), 1);
    chk("ready_enable", 32'(enable), 1);
    tick(4); btn_start = 1'b0; tick(16);
    chk("release_state", 32'(state), 1);

    // Jump press enters PLAY; jump level visible while held.
    btn_jump = 1'b1; tick(16);
    chk("play_state", 32'(state), 2);
    chk("jump_level", 32'(jump), 1);
    btn_jump = 1'b0; tick(16);
    chk("jump_released", 32'(jump), 0);

    // Down level in PLAY.
    btn_down = 1'b1; tick(16);
    chk("down_level", 32'(down), 1);
    btn_down = 1'b0; tick(16);

    // Game 1: score 9, then ground timeout with an interruption.
    pulses(9);
    chk("g1_score", 32'(score), 9);
    chk("g1_fa", 32'(fall_accel), 1);
    y_coord = 11'sd0; tick(40);
    y_coord = 11'sd5; tick(1);
    y_coord = -11'sd2; tick(63);
    chk("ground63_state", 32'(state), 2);
    tick(1);
    chk("ground64_state", 32'(state), 3);
    chk("g1_hs", 32'(high_score), 9);
    chk("over_enable", 32'(enable), 0);
    y_coord = 11'sd100;
    tick(1023);
    chk("over1023_state", 32'(state), 3);
    chk("over_score_hold", 32'(score), 9);
    tick(1);
    chk("over1024_state", 32'(state), 0);

    // Game 2: score clears, level step, pause, collision+pipe at 14.
    btn_start = 1'b1; tick(16);
    chk("g2_ready", 32'(state), 1);
    chk("g2_score_clr", 32'(score), 0);
    btn_start = 1'b0; tick(16);
    press_jump();
    chk("g2_play", 32'(state), 2);
    pulses(9);
    pipe_passed = 1'b1; tick(1); pipe_passed = 1'b0;
    chk("g2_score10", 32'(score), 10);
    chk("g2_fa_lag", 32'(fall_accel), 1);
    tick(1);
    chk("g2_fa2", 32'(fall_accel), 2);
    pulses(2);
    chk("g2_score12", 32'(score), 12);
    chk("g2_fa2b", 32'(fall_accel), 2);

    btn_start = 1'b1; tick(16);
    chk("pause_enable", 32'(enable), 0);
    btn_start = 1'b0; collision = 1'b1; tick(16);
    pulses(1);
    chk("pause_state", 32'(state), 2);
    chk("pause_score", 32'(score), 12);
    collision = 1'b0; tick(1);
    btn_start = 1'b1; tick(16);
    chk("resume_enable", 32'(enable), 1);
    btn_start = 1'b0; tick(16);
    pulses(2);
    chk("g2_score14", 32'(score), 14);
    collision = 1'b1; pipe_passed = 1'b1; tick(1);
    collision = 1'b0; pipe_passed = 1'b0;
    chk("g2_over", 32'(state), 3);
    chk("g2_final_score", 32'(score), 15);
    chk("g2_hs", 32'(high_score), 15);

    // Start press in OVER returns to IDLE immediately.
    btn_start = 1'b1; tick(15);
    chk("over_start15", 32'(state), 3);
    tick(1);
    chk("over_start16", 32'(state), 0);
    btn_start = 1'b0; tick(16);

    // Game 3: ends at 4, high score stays 15.
    press_start();
    press_jump();
    pulses(4);
    collision = 1'b1; tick(1); collision = 1'b0;
    chk("g3_over", 32'(state), 3);
    chk("g3_score", 32'(score), 4);
    chk("g3_hs", 32'(high_score), 15);
    press_start();
    chk("g3_idle", 32'(state), 0);

    // Game 4: saturation at 999.
    press_start();
    press_jump();
    pipe_passed = 1'b1;
    tick(998);
    chk("sat_998", 32'(score), 998);
    tick(1);
    chk("sat_999", 32'(score), 999);
    tick(3);
    pipe_passed = 1'b0;
    chk("sat_hold", 32'(score), 999);
    tick(1);
    chk("sat_fa3", 32'(fall_accel), 3);
    collision = 1'b1; tick(1); collision = 1'b0;
    chk("g4_hs", 32'(high_score), 999);
    press_start();

    // Game 5: reset mid-PLAY with score 7.
    press_start();
    press_jump();
    pulses(7);
    chk("g5_score", 32'(score), 7);
    rst = 1'b1; tick(2); rst = 1'b0;
    chk("rst_state", 32'(state), 0);
    chk("rst_enable", 32'(enable), 0);
    chk("rst_score", 32'(score), 0);
    chk("rst_hs", 32'(high_score), 0);
    chk("rst_fa", 32'(fall_accel), 1);

    // Down level is forced low outside PLAY.
    btn_down = 1'b1; tick(20);
    chk("down_idle", 32'(down), 0);
    btn_down = 1'b0; tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
